// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2,
    EOP   = 2'd3
  } tx_state_t;

  localparam int STUFF_LIMIT = 6;
  localparam int EOP_BITS    = 2;

  // NRZI: a 0 toggles the line, a 1 holds it.
  function automatic logic nrzi_next(input logic level, input logic data_bit);
    return data_bit ? level : ~level;
  endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register; load wins over shift, vacated bits fill with 1.
module flex_pts_sr #(
  parameter int NUM_BITS  = 4,
  parameter int SHIFT_MSB = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr <= '1;
    end else if (load_enable) begin
      sr <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB != 0) sr <= {sr[NUM_BITS-2:0], 1'b1};
      else                sr <= {1'b1, sr[NUM_BITS-1:1]};
    end
  end

  assign serial_out = (SHIFT_MSB != 0) ? sr[NUM_BITS-1] : sr[0];

endmodule

// File: rtl/usb_tx_serializer.sv
// USB byte transmitter: one-entry hold register, LSB-first serializer with
// bit stuffing, NRZI line coding and an SE0-style EOP.
//
//   state | meaning
//   IDLE  | line at 1, waiting for a held byte
//   SHIFT | driving a data bit for one bit period
//   STUFF | driving an inserted stuff bit after six consecutive 1s
//   EOP   | line at 0 for EOP_BITS bit periods
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  input  logic                 tx_last,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_active,
  output logic                 tx_err
);

  localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  tx_state_t            state;
  logic [TMR_W-1:0]     bit_tmr;
  logic [IDX_W-1:0]     bit_idx;
  logic [2:0]           ones_cnt;
  logic [1:0]           eop_cnt;
  logic                 nrzi_level;
  logic                 cur_last;
  logic                 hold_full;
  logic                 hold_last;
  logic [DATA_BITS-1:0] hold_data;
  logic                 sr_out;

  logic bit_end;
  logic more_bits;
  logic stuff_due;
  logic at_pending;
  logic shift_now;
  logic byte_end;
  logic load_now;
  logic tx_bit;
  logic level_next;
  logic [2:0] ones_next;

  assign tx_ready = !hold_full;

  always_comb begin
    bit_end    = (bit_tmr == TMR_W'(CLKS_PER_BIT - 1));
    more_bits  = (bit_idx != IDX_W'(DATA_BITS - 1));
    stuff_due  = (ones_cnt == 3'(STUFF_LIMIT));
    // A bit period just finished and nothing forces a stuff bit first.
    at_pending = bit_end && ((state == SHIFT && !stuff_due) || state == STUFF);
    shift_now  = at_pending && more_bits;
    byte_end   = at_pending && !more_bits;
    load_now   = (state == IDLE && hold_full) || (byte_end && !cur_last && hold_full);
    // The shifter is loaded with bits 1.. so its output is always the next bit.
    tx_bit     = load_now ? hold_data[0] : sr_out;
    level_next = nrzi_next((state == IDLE) ? 1'b1 : nrzi_level, tx_bit);
    if (!tx_bit)              ones_next = 3'd0;
    else if (state == IDLE)   ones_next = 3'd1;
    else                      ones_next = ones_cnt + 3'd1;
  end

  flex_pts_sr #(
    .NUM_BITS (DATA_BITS),
    .SHIFT_MSB(0)
  ) u_pts (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_enable (load_now),
    .shift_enable(shift_now),
    .parallel_in ({1'b1, hold_data[DATA_BITS-1:1]}),
    .serial_out  (sr_out)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      bit_tmr    <= '0;
      bit_idx    <= '0;
      ones_cnt   <= '0;
      eop_cnt    <= '0;
      nrzi_level <= 1'b1;
      cur_last   <= 1'b0;
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
      serial_out <= 1'b1;
      tx_active  <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_err <= 1'b0;

      // Accept and load are exclusive: accept needs an empty hold, load a full one.
      if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
        hold_last <= tx_last;
      end else if (load_now) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          bit_tmr    <= '0;
          serial_out <= 1'b1;
          if (load_now) begin
            state      <= SHIFT;
            bit_idx    <= '0;
            cur_last   <= hold_last;
            nrzi_level <= level_next;
            serial_out <= level_next;
            ones_cnt   <= ones_next;
            tx_active  <= 1'b1;
          end
        end

        SHIFT, STUFF: begin
          bit_tmr <= bit_end ? '0 : bit_tmr + TMR_W'(1);
          if (state == SHIFT && bit_end && stuff_due) begin
            state      <= STUFF;
            nrzi_level <= ~nrzi_level;
            serial_out <= ~nrzi_level;
            ones_cnt   <= '0;
          end else if (shift_now) begin
            state      <= SHIFT;
            bit_idx    <= bit_idx + IDX_W'(1);
            nrzi_level <= level_next;
            serial_out <= level_next;
            ones_cnt   <= ones_next;
          end else if (load_now) begin
            state      <= SHIFT;
            bit_idx    <= '0;
            cur_last   <= hold_last;
            nrzi_level <= level_next;
            serial_out <= level_next;
            ones_cnt   <= ones_next;
          end else if (byte_end && cur_last) begin
            state      <= EOP;
            eop_cnt    <= '0;
            serial_out <= 1'b0;
          end else if (byte_end) begin
            // Underrun: abandon the packet without an EOP.
            state      <= IDLE;
            tx_err     <= 1'b1;
            serial_out <= 1'b1;
            nrzi_level <= 1'b1;
            ones_cnt   <= '0;
            tx_active  <= 1'b0;
          end
        end

        EOP: begin
          bit_tmr <= bit_end ? '0 : bit_tmr + TMR_W'(1);
          if (bit_end) begin
            if (eop_cnt == 2'(EOP_BITS - 1)) begin
              state      <= IDLE;
              serial_out <= 1'b1;
              nrzi_level <= 1'b1;
              ones_cnt   <= '0;
              tx_active  <= 1'b0;
            end else begin
              eop_cnt <= eop_cnt + 2'd1;
            end
          end
        end

        default: begin
          state      <= IDLE;
          serial_out <= 1'b1;
          nrzi_level <= 1'b1;
          tx_active  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Scoreboarded bench: packets expand into expected per-bit-period line levels.
module tb_usb_tx_serializer;

  localparam int CPB = 8;

  typedef struct {
    int n_periods;
    bit err;
  } pkt_t;

  logic       clk;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       serial_out;
  logic       tx_active;
  logic       tx_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] byte_q[$];
  logic       exp_lv[$];
  pkt_t       pkt_q[$];

  bit   in_pkt = 0;
  int   cyc = 0;
  int   periods = 0;
  logic cur_lv = 1'b1;
  bit   period_bad = 0;

  usb_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .serial_out(serial_out),
    .tx_active (tx_active),
    .tx_err    (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: LSB-first bits, stuff a 0 after six 1s, NRZI from an idle 1, then EOP zeros.
  task automatic expect_pkt(input bit ends_last);
    logic       level;
    int         ones;
    int         n;
    logic [7:0] b;
    pkt_t       p;
    level = 1'b1;
    ones  = 0;
    n     = 0;
    foreach (byte_q[k]) begin
      b = byte_q[k];
      for (int i = 0; i < 8; i++) begin
        if (b[i] == 1'b0) level = ~level;
        ones = b[i] ? ones + 1 : 0;
        exp_lv.push_back(level);
        n++;
        if (ones == 6) begin
          level = ~level;
          exp_lv.push_back(level);
          n++;
          ones = 0;
        end
      end
    end
    if (ends_last) begin
      exp_lv.push_back(1'b0);
      exp_lv.push_back(1'b0);
      n += 2;
    end
    p.n_periods = n;
    p.err       = !ends_last;
    pkt_q.push_back(p);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("handshake_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic send_pkt(input bit ends_last);
    expect_pkt(ends_last);
    for (int i = 0; i < byte_q.size(); i++)
      send_byte(byte_q[i], ends_last && (i == byte_q.size() - 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((in_pkt || pkt_q.size() != 0 || !tx_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 5000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: grades each bit period while tx_active, and the packet tail when it drops.
  always @(negedge clk) begin
    if (!n_rst) begin
      exp_lv.delete();
      pkt_q.delete();
      in_pkt  = 0;
      cyc     = 0;
      periods = 0;
    end else if (tx_active) begin
      if (!in_pkt) begin
        in_pkt  = 1;
        cyc     = 0;
        periods = 0;
        if (pkt_q.size() == 0) chk("unexpected_packet", 32'd1, 32'd0);
      end
      if (cyc == 0) begin
        period_bad = 0;
        cur_lv = (exp_lv.size() > 0) ? exp_lv.pop_front() : 1'bx;
      end
      if (serial_out !== cur_lv) period_bad = 1;
      cyc++;
      if (cyc == CPB) begin
        chk($sformatf("bit_period_%0d", periods), 32'(period_bad), 32'd0);
        periods++;
        cyc = 0;
      end
    end else if (in_pkt) begin
      pkt_t p;
      in_pkt = 0;
      if (pkt_q.size() > 0) begin
        p = pkt_q.pop_front();
        chk("pkt_periods", 32'(periods), 32'(p.n_periods));
        chk("pkt_partial_cycles", 32'(cyc), 32'd0);
        chk("pkt_end_err", 32'(tx_err), 32'(p.err));
      end
      chk("pkt_end_line", 32'(serial_out), 32'd1);
    end else if (tx_err) begin
      chk("spurious_err", 32'(tx_err), 32'd0);
    end
  end

  initial begin
    bit quiet;
    n_rst    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
    #3 n_rst = 1'b0;
    #1;
    chk("rst_serial_out", 32'(serial_out), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_tx_active", 32'(tx_active), 32'd0);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // 0x00 single byte, with first-bit latency
    byte_q = {8'h00};
    expect_pkt(1'b1);
    send_byte(8'h00, 1'b1);
    chk("lat_active_k", 32'(tx_active), 32'd0);
    chk("lat_ready_k", 32'(tx_ready), 32'd0);
    @(negedge clk);
    chk("lat_active_k1", 32'(tx_active), 32'd1);
    chk("lat_line_k1", 32'(serial_out), 32'd0);
    chk("lat_ready_k1", 32'(tx_ready), 32'd1);
    wait_idle();

    byte_q = {8'hFF};
    send_pkt(1'b1);
    wait_idle();

    byte_q = {8'hA5, 8'h3C};
    send_pkt(1'b1);
    wait_idle();

    byte_q = {8'h0F, 8'hF0, 8'hFF, 8'h01};
    send_pkt(1'b1);
    wait_idle();

    // Underrun: not last and nothing follows
    byte_q = {8'h55};
    send_pkt(1'b0);
    wait_idle();

    // Reset during bit 3 with a second byte already held
    byte_q = {8'h3A, 8'hC5};
    send_pkt(1'b1);
    repeat (25) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_serial_out", 32'(serial_out), 32'd1);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_tx_active", 32'(tx_active), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    quiet = 1;
    repeat (40) begin
      @(negedge clk);
      if (tx_active || !serial_out || tx_err) quiet = 0;
    end
    chk("post_rst_quiet", 32'(quiet), 32'd1);

    // Randomized packets, biased toward long runs of ones
    for (int p = 0; p < 25; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      byte_q.delete();
      for (int i = 0; i < nb; i++) begin
        case ($urandom_range(0, 3))
          0:       byte_q.push_back(8'hFF);
          1:       byte_q.push_back(8'h7E | 8'($urandom_range(0, 1)));
          default: byte_q.push_back(8'($urandom));
        endcase
      end
      send_pkt(1'b1);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
